// File: rtl/phy_sym_pkg.sv
// Shared symbol codes and types for the receive deframer.
package phy_sym_pkg;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_COM = 8'hBC;

    typedef enum logic [1:0] {
        OS_NONE = 2'b00,
        OS_SKP  = 2'b01,
        OS_IDL  = 2'b10,
        OS_FTS  = 2'b11
    } os_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PKT  = 2'b01,
        ST_OS   = 2'b10
    } rx_state_t;

    // Maps a K-code to its ordered-set type; OS_NONE for anything that cannot follow COM.
    function automatic os_type_t os_type_of(input logic [7:0] sym);
        os_type_t t;
        case (sym)
            K_SKP:   t = OS_SKP;
            K_IDL:   t = OS_IDL;
            K_FTS:   t = OS_FTS;
            default: t = OS_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/phy_rx_os_checker.sv
// Ordered-set body checker: counts symbols after COM and verifies they all carry the same type.
module phy_rx_os_checker
    import phy_sym_pkg::*;
#(
    parameter int OS_SYMS = 3
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] sym,
    input  logic       sym_k,
    output logic       done,
    output logic       mismatch,
    output os_type_t   os_type
);

    localparam int CNT_W = $clog2(OS_SYMS + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    os_type_t         type_reg, type_next;
    os_type_t         sym_type;
    logic             sym_ok;
    logic             last_sym;

    always_comb begin
        sym_type = os_type_of(sym);
        // The first body symbol fixes the type; the rest must repeat it.
        sym_ok   = sym_k && (sym_type != OS_NONE) &&
                   ((cnt_reg == '0) || (sym_type == type_reg));
        last_sym = (cnt_reg == CNT_W'(OS_SYMS - 1));
        done     = step && sym_ok && last_sym;
        mismatch = step && !sym_ok;
        os_type  = sym_type;

        cnt_next  = cnt_reg;
        type_next = type_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (step) begin
            if (sym_ok && !last_sym) begin
                cnt_next  = cnt_reg + 1'b1;
                type_next = sym_type;
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            type_reg <= OS_NONE;
        end else begin
            cnt_reg  <= cnt_next;
            type_reg <= type_next;
        end
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive symbol deframer: recovers STP/SDP..END/EDB packets and COM ordered sets from the lane.
// Optional PHY_RX_ERR_CNT_EN adds a saturating framing-error counter on ERR_CNT.
module phy_rx_deframer
    import phy_sym_pkg::*;
#(
    parameter int MAX_PKT_LEN = 64,
    parameter int OS_SYMS     = 3
`ifdef PHY_RX_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W   = 16
`endif
) (
    input  logic       CLK0,
    input  logic       RESET,
    input  logic [7:0] SYM_IN,
    input  logic       SYM_K,
    input  logic       SYM_VALID,
    output logic [7:0] D_OUT,
    output logic       D_VALID,
    output logic       PKT_START,
    output logic       PKT_TYPE,
    output logic       PKT_END,
    output logic       PKT_ABORT,
    output logic       OS_VALID,
    output logic [1:0] OS_TYPE,
    output logic       ERROR_DLL
`ifdef PHY_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

    rx_state_t        state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;

    logic [7:0] d_out_reg, d_out_next;
    logic       d_valid_reg, d_valid_next;
    logic       pkt_start_reg, pkt_start_next;
    logic       pkt_type_reg, pkt_type_next;
    logic       pkt_end_reg, pkt_end_next;
    logic       pkt_abort_reg, pkt_abort_next;
    logic       os_valid_reg, os_valid_next;
    logic [1:0] os_type_reg, os_type_next;
    logic       err_reg, err_next;

    logic       os_clear;
    logic       os_step;
    logic       os_done;
    logic       os_mismatch;
    os_type_t   os_sym_type;

    assign os_step = SYM_VALID && (state_reg == ST_OS);

    phy_rx_os_checker #(
        .OS_SYMS (OS_SYMS)
    ) u_os_checker (
        .clk      (CLK0),
        .srst     (RESET),
        .clear    (os_clear),
        .step     (os_step),
        .sym      (SYM_IN),
        .sym_k    (SYM_K),
        .done     (os_done),
        .mismatch (os_mismatch),
        .os_type  (os_sym_type)
    );

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        d_out_next     = d_out_reg;
        d_valid_next   = 1'b0;
        pkt_start_next = 1'b0;
        pkt_type_next  = pkt_type_reg;
        pkt_end_next   = 1'b0;
        pkt_abort_next = 1'b0;
        os_valid_next  = 1'b0;
        os_type_next   = os_type_reg;
        err_next       = 1'b0;
        os_clear       = 1'b0;

        if (SYM_VALID) begin
            case (state_reg)
                ST_IDLE: begin
                    if (SYM_K && (SYM_IN == K_STP || SYM_IN == K_SDP)) begin
                        state_next     = ST_PKT;
                        pkt_start_next = 1'b1;
                        pkt_type_next  = (SYM_IN == K_SDP);
                        len_next       = '0;
                    end else if (SYM_K && SYM_IN == K_COM) begin
                        state_next = ST_OS;
                        os_clear   = 1'b1;
                    end else if (SYM_K || SYM_IN != 8'h00) begin
                        err_next = 1'b1;
                    end
                end

                ST_PKT: begin
                    if (!SYM_K) begin
                        if (len_reg == LEN_W'(MAX_PKT_LEN)) begin
                            err_next       = 1'b1;
                            pkt_end_next   = 1'b1;
                            pkt_abort_next = 1'b1;
                            state_next     = ST_IDLE;
                        end else begin
                            d_valid_next = 1'b1;
                            d_out_next   = SYM_IN;
                            len_next     = len_reg + 1'b1;
                        end
                    end else begin
                        // Every K-symbol other than a good END closes the packet as nullified.
                        pkt_end_next   = 1'b1;
                        pkt_abort_next = 1'b1;
                        state_next     = ST_IDLE;
                        case (SYM_IN)
                            K_END: begin
                                if (len_reg != '0) begin
                                    pkt_abort_next = 1'b0;
                                end else begin
                                    err_next = 1'b1;
                                end
                            end
                            K_EDB: ;
                            K_STP, K_SDP: begin
                                err_next       = 1'b1;
                                pkt_start_next = 1'b1;
                                pkt_type_next  = (SYM_IN == K_SDP);
                                len_next       = '0;
                                state_next     = ST_PKT;
                            end
                            K_COM: begin
                                err_next   = 1'b1;
                                os_clear   = 1'b1;
                                state_next = ST_OS;
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                end

                ST_OS: begin
                    if (os_done) begin
                        os_valid_next = 1'b1;
                        os_type_next  = os_sym_type;
                        state_next    = ST_IDLE;
                    end else if (os_mismatch) begin
                        err_next   = 1'b1;
                        state_next = (SYM_K && SYM_IN == K_COM) ? ST_OS : ST_IDLE;
                    end
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK0) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            d_out_reg     <= 8'h00;
            d_valid_reg   <= 1'b0;
            pkt_start_reg <= 1'b0;
            pkt_type_reg  <= 1'b0;
            pkt_end_reg   <= 1'b0;
            pkt_abort_reg <= 1'b0;
            os_valid_reg  <= 1'b0;
            os_type_reg   <= 2'b00;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            d_out_reg     <= d_out_next;
            d_valid_reg   <= d_valid_next;
            pkt_start_reg <= pkt_start_next;
            pkt_type_reg  <= pkt_type_next;
            pkt_end_reg   <= pkt_end_next;
            pkt_abort_reg <= pkt_abort_next;
            os_valid_reg  <= os_valid_next;
            os_type_reg   <= os_type_next;
            err_reg       <= err_next;
        end
    end

    assign D_OUT     = d_out_reg;
    assign D_VALID   = d_valid_reg;
    assign PKT_START = pkt_start_reg;
    assign PKT_TYPE  = pkt_type_reg;
    assign PKT_END   = pkt_end_reg;
    assign PKT_ABORT = pkt_abort_reg;
    assign OS_VALID  = os_valid_reg;
    assign OS_TYPE   = os_type_reg;
    assign ERROR_DLL = err_reg;

`ifdef PHY_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge CLK0) begin
        if (RESET) begin
            err_cnt_reg <= '0;
        end else if (err_next && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign ERR_CNT = err_cnt_reg;
`endif

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Bench for phy_rx_deframer: directed scenarios plus randomized framing traffic checked against a behavioural model.
module tb_phy_rx_deframer;

    logic       CLK0 = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] SYM_IN = 8'h00;
    logic       SYM_K = 1'b0;
    logic       SYM_VALID = 1'b0;
    logic [7:0] D_OUT;
    logic       D_VALID, PKT_START, PKT_TYPE, PKT_END, PKT_ABORT, OS_VALID, ERROR_DLL;
    logic [1:0] OS_TYPE;
`ifdef PHY_RX_ERR_CNT_EN
    logic [15:0] ERR_CNT;
`endif

    phy_rx_deframer dut (
        .CLK0      (CLK0),
        .RESET     (RESET),
        .SYM_IN    (SYM_IN),
        .SYM_K     (SYM_K),
        .SYM_VALID (SYM_VALID),
        .D_OUT     (D_OUT),
        .D_VALID   (D_VALID),
        .PKT_START (PKT_START),
        .PKT_TYPE  (PKT_TYPE),
        .PKT_END   (PKT_END),
        .PKT_ABORT (PKT_ABORT),
        .OS_VALID  (OS_VALID),
        .OS_TYPE   (OS_TYPE),
        .ERROR_DLL (ERROR_DLL)
`ifdef PHY_RX_ERR_CNT_EN
        ,
        .ERR_CNT   (ERR_CNT)
`endif
    );

    always #5 CLK0 = ~CLK0;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "where are we" as plain flags, OS body kept as a list of received symbols.
    bit         m_in_pkt, m_in_os;
    int         m_len;
    logic [7:0] m_os_q[$];
    logic [7:0] m_dout;
    logic       m_ptype;
    logic [1:0] m_ostype;
    int         m_errcnt;
    logic       e_dv, e_start, e_end, e_abort, e_osv, e_err;

    function automatic logic [1:0] os_code(input logic [7:0] s);
        if (s == 8'h1C) return 2'b01;
        if (s == 8'h7C) return 2'b10;
        if (s == 8'h3C) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_in_pkt = 0; m_in_os = 0; m_len = 0; m_os_q.delete();
        m_dout = 8'h00; m_ptype = 0; m_ostype = 2'b00; m_errcnt = 0;
        {e_dv, e_start, e_end, e_abort, e_osv, e_err} = '0;
    endtask

    task automatic model_sym(input bit k, input logic [7:0] s);
        {e_dv, e_start, e_end, e_abort, e_osv, e_err} = '0;
        if (m_in_os) begin
            if (k && os_code(s) != 2'b00 && (m_os_q.size() == 0 || s == m_os_q[0])) begin
                m_os_q.push_back(s);
                if (m_os_q.size() == 3) begin
                    e_osv = 1; m_ostype = os_code(s); m_in_os = 0; m_os_q.delete();
                end
            end else begin
                e_err = 1; m_os_q.delete();
                m_in_os = k && (s == 8'hBC);
            end
        end else if (m_in_pkt) begin
            if (!k) begin
                if (m_len == 64) begin
                    e_err = 1; e_end = 1; e_abort = 1; m_in_pkt = 0;
                end else begin
                    e_dv = 1; m_dout = s; m_len++;
                end
            end else begin
                e_end = 1; m_in_pkt = 0;
                if (s == 8'hFD) begin
                    if (m_len == 0) begin e_abort = 1; e_err = 1; end
                end else if (s == 8'hFE) begin
                    e_abort = 1;
                end else if (s == 8'hFB || s == 8'h5C) begin
                    e_abort = 1; e_err = 1; e_start = 1;
                    m_ptype = (s == 8'h5C); m_len = 0; m_in_pkt = 1;
                end else if (s == 8'hBC) begin
                    e_abort = 1; e_err = 1; m_in_os = 1; m_os_q.delete();
                end else begin
                    e_abort = 1; e_err = 1;
                end
            end
        end else begin
            if (k && (s == 8'hFB || s == 8'h5C)) begin
                e_start = 1; m_ptype = (s == 8'h5C); m_len = 0; m_in_pkt = 1;
            end else if (k && s == 8'hBC) begin
                m_in_os = 1; m_os_q.delete();
            end else if (k || s != 8'h00) begin
                e_err = 1;
            end
        end
        if (e_err && m_errcnt < 65535) m_errcnt++;
    endtask

    task automatic check(input string tag);
        logic [16:0] obs, exp;
        obs = {D_VALID, D_OUT, PKT_START, PKT_TYPE, PKT_END, PKT_ABORT, OS_VALID, OS_TYPE, ERROR_DLL};
        exp = {e_dv, m_dout, e_start, m_ptype, e_end, e_abort, e_osv, m_ostype, e_err};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs={dv,dout,st,ty,end,ab,osv,ost,err}=%h exp=%h", tag, obs, exp);
        end
`ifdef PHY_RX_ERR_CNT_EN
        n_vec++;
        assert (ERR_CNT === 16'(m_errcnt)) else begin
            n_err++;
            $error("FAIL %s_errcnt obs=%0d exp=%0d", tag, ERR_CNT, m_errcnt);
        end
`endif
    endtask

    // One cycle: drive at negedge, the DUT samples at posedge, outputs checked at the next negedge.
    task automatic step(input string tag, input bit v, input bit k, input logic [7:0] s);
        SYM_VALID = v; SYM_K = k; SYM_IN = s;
        if (v) model_sym(k, s);
        else {e_dv, e_start, e_end, e_abort, e_osv, e_err} = '0;
        @(posedge CLK0);
        @(negedge CLK0);
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        RESET = 1; SYM_VALID = 1; SYM_K = 0; SYM_IN = 8'h55;
        model_reset();
        @(posedge CLK0);
        @(negedge CLK0);
        check(tag);
        RESET = 0; SYM_VALID = 0;
    endtask

    task automatic rand_stall(input string tag);
        while ($urandom_range(0, 9) < 2) step(tag, 0, $urandom_range(0, 1), 8'($urandom));
    endtask

    logic [7:0] kcodes[9] = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h1C, 8'h7C, 8'h3C, 8'hBC, 8'hF7};
    logic [7:0] ostab[3] = '{8'h1C, 8'h7C, 8'h3C};

    initial begin
        model_reset();
        @(negedge CLK0);
        do_reset("reset");
        do_reset("reset2");

        // 1: TLP with three bytes
        step("t1_stp", 1, 1, 8'hFB);
        step("t1_d0", 1, 0, 8'h01);
        step("t1_d1", 1, 0, 8'h02);
        step("t1_d2", 1, 0, 8'h10);
        step("t1_end", 1, 1, 8'hFD);

        // 2: DLLP nullified by EDB
        step("t2_sdp", 1, 1, 8'h5C);
        step("t2_d0", 1, 0, 8'h20);
        step("t2_d1", 1, 0, 8'h40);
        step("t2_edb", 1, 1, 8'hFE);

        // 3: SKP then IDL ordered sets
        step("t3_com", 1, 1, 8'hBC);
        for (int i = 0; i < 3; i++) step("t3_skp", 1, 1, 8'h1C);
        step("t3_com2", 1, 1, 8'hBC);
        for (int i = 0; i < 3; i++) step("t3_idl", 1, 1, 8'h7C);

        // 4: mixed OS body, then empty packet
        step("t4_com", 1, 1, 8'hBC);
        step("t4_skp", 1, 1, 8'h1C);
        step("t4_idl", 1, 1, 8'h7C);
        step("t4_stp", 1, 1, 8'hFB);
        step("t4_end", 1, 1, 8'hFD);

        // 5: overlong packet with stalls
        step("t5_stp", 1, 1, 8'hFB);
        for (int i = 0; i < 65; i++) begin
            if (i % 7 == 3) step("t5_stall", 0, 1, 8'hFD);
            step("t5_byte", 1, 0, 8'(i + 1));
        end
        step("t5_after", 1, 0, 8'h00);

        // 6: reset mid-packet
        step("t6_stp", 1, 1, 8'h5C);
        for (int i = 0; i < 3; i++) step("t6_byte", 1, 0, 8'hA0 + 8'(i));
        do_reset("t6_reset");
        step("t6_idle", 1, 0, 8'h00);

        // Randomized framing traffic
        for (int ev = 0; ev < 200; ev++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                int len, term;
                len = $urandom_range(0, 70);
                step("r_start", 1, 1, ($urandom_range(0, 1) != 0) ? 8'hFB : 8'h5C);
                for (int i = 0; i < len; i++) begin
                    rand_stall("r_stall");
                    step("r_data", 1, 0, 8'($urandom));
                end
                term = $urandom_range(0, 5);
                if (term < 3) step("r_end", 1, 1, 8'hFD);
                else if (term == 3) step("r_edb", 1, 1, 8'hFE);
                else step("r_term", 1, 1, kcodes[$urandom_range(0, 8)]);
            end else if (kind < 7) begin
                logic [7:0] t;
                t = ostab[$urandom_range(0, 2)];
                step("r_com", 1, 1, 8'hBC);
                for (int i = 0; i < 3; i++) begin
                    rand_stall("r_stall");
                    if ($urandom_range(0, 9) == 0) step("r_osbad", 1, $urandom_range(0, 1), kcodes[$urandom_range(0, 8)]);
                    else step("r_os", 1, 1, t);
                end
            end else if (kind < 9) begin
                for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
                    if ($urandom_range(0, 1) != 0) step("r_junk", 1, 1, kcodes[$urandom_range(0, 8)]);
                    else step("r_junk", 1, 0, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
                end
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset("r_reset");
                else rand_stall("r_stall");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
